pc_upstream_serializer: RTL and testbench
=========================================

Name: pc_upstream_serializer

Overview:
- Mirror of the downstream PC configuration path: it packs FPGA-generated upstream traffic into narrow words for the PC-bound link.
- It accepts wide messages from the SpikeFilter output (filter index + state) and the TimeMgr heartbeat (time value).
- It arbitrates round-robin between the two sources and serializes the winner LSB-first into Nout-bit words.
- Each output word carries a route code and a last flag.

Parameters:
- Nout, 16: output word width; payload chunk width is Nout-3.
- N_SF_filts, 10: filter index width.
- N_SF_state, 27: filter state width.
- N_TM_time, 48: heartbeat time width.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- sf_v  input  1  SpikeFilter message valid
- sf_d  input  N_SF_filts+N_SF_state  SpikeFilter message; {filt_idx, state}, state in the LSBs
- sf_a  output  1  SpikeFilter message accepted
- hb_v  input  1  heartbeat message valid
- hb_d  input  N_TM_time  heartbeat time value
- hb_a  output  1  heartbeat message accepted
- out_v  output  1  output word valid
- out_d  output  Nout  output word {code[1:0], last, chunk[Nout-4:0]}
- out_a  input  1  downstream accepts the word

Behaviour:
- Handshake on all channels: a transfer occurs in any cycle where v && a.
- Producers hold v and d stable until accepted.
- Block holds out_v and out_d stable until out_a.
- Chunk width C = Nout-3.
- Chunk counts:
  - SF: Ksf = ceil((N_SF_filts+N_SF_state)/C); default 3.
  - HB: Khb = ceil(N_TM_time/C); default 4.
- Payload is zero-extended to K*C bits; chunk i = payload[i*C +: C].
- Route codes: SF = 2'b00, HB = 2'b01; 2'b10 and 2'b11 are reserved and never emitted.
- FSM states: IDLE, SEND.
- IDLE:
  - out_v = 0.
  - If exactly one source is valid, grant it.
  - If both are valid, grant the source not granted most recently; after reset SF wins the first tie.
  - The grant drives the combinational sf_a or hb_a = 1 in the same cycle.
  - On grant: latch payload and code, set K, clear chunk index, update last_grant, go to SEND.
  - Non-granted a = 0.
- SEND:
  - sf_a = hb_a = 0; out_v = 1.
  - out_d = {code, idx==K-1, chunk[idx]}.
  - On out_a with idx < K-1: idx increments.
  - On out_a with idx == K-1: go to IDLE.
- Latency: input accepted in cycle N; first output word valid in cycle N+1.
- Throughput: K words per message plus 1 IDLE cycle between messages.
- Back-pressure: out_a low holds the current word indefinitely; no input is accepted while in SEND.
- A source deasserting v while not granted is legal; no state is kept for it.
- Reset (any state, including mid-message):
  - Next cycle: state IDLE, out_v = 0, sf_a = hb_a = 0.
  - idx = 0, last_grant = HB (so SF wins the next tie).
  - Any partially sent message is discarded; the partial stream is not resumed.
- Reset values of outputs: out_v = 0, out_d = 0, sf_a = 0, hb_a = 0.
- Width rule: K is computed at elaboration; the idx counter is wide enough for max(Ksf, Khb)-1.

Test Plan:
- SF single message, default params: sf_d = {10'h003, 27'h0000005}, out_a tied 1.
  - Required: sf_a high for one cycle.
  - out_d sequence 16'h0005, 16'h0000, 16'h2006, with out_v on 3 consecutive cycles starting 1 cycle after acceptance.
- HB single message: hb_d = 48'h1, out_a tied 1.
  - Required: out_d sequence 16'h4001, 16'h4000, 16'h4000, 16'h6000; last flag only on the 4th word.
- Tie arbitration: sf_v and hb_v held high continuously from reset.
  - Required: grant order SF, HB, SF, HB.
  - Exactly one IDLE cycle between messages; no word interleaving across messages.
- Back-pressure: HB message with out_a low for 5 cycles on the 2nd word.
  - Required: out_d stays 16'h4000 with out_v = 1 throughout; hb_a stays 0; sequence resumes intact.
- Reset mid-message: assert reset during the 2nd word of an SF message.
  - Required: out_v = 0 the next cycle.
  - A new SF message after reset starts from chunk 0 with correct words; no stale chunk is emitted.
- Reset priority: after reset, sf_v and hb_v rise in the same cycle.
  - Required: SF granted first.

Source files
------------

// File: rtl/pc_upstream_serializer_if.sv
// rtl/pc_upstream_serializer_if.sv - SpikeFilter, heartbeat and PC-bound word channels
interface pc_upstream_serializer_if #(
  parameter int Nout       = 16,
  parameter int N_SF_filts = 10,
  parameter int N_SF_state = 27,
  parameter int N_TM_time  = 48
);
  logic                             sf_v;
  logic [N_SF_filts+N_SF_state-1:0] sf_d;
  logic                             sf_a;
  logic                             hb_v;
  logic [N_TM_time-1:0]             hb_d;
  logic                             hb_a;
  logic                             out_v;
  logic [Nout-1:0]                  out_d;
  logic                             out_a;

  modport master (
    output sf_v, sf_d, hb_v, hb_d, out_a,
    input  sf_a, hb_a, out_v, out_d
  );

  modport slave (
    input  sf_v, sf_d, hb_v, hb_d, out_a,
    output sf_a, hb_a, out_v, out_d
  );
endinterface

// File: rtl/pc_upstream_serializer.sv
// rtl/pc_upstream_serializer.sv - round-robin SF/heartbeat packer into narrow PC-bound words
module pc_upstream_serializer #(
  parameter int Nout       = 16,
  parameter int N_SF_filts = 10,
  parameter int N_SF_state = 27,
  parameter int N_TM_time  = 48
) (
  input  logic                     clk,
  input  logic                     reset,
  pc_upstream_serializer_if.slave  bus
);
  localparam int C    = Nout - 3;
  localparam int W_SF = N_SF_filts + N_SF_state;
  localparam int W_HB = N_TM_time;
  localparam int KSF  = (W_SF + C - 1) / C;
  localparam int KHB  = (W_HB + C - 1) / C;
  localparam int KMAX = (KSF > KHB) ? KSF : KHB;
  localparam int PW   = KMAX * C;
  localparam int IW   = (KMAX > 1) ? $clog2(KMAX) : 1;

  localparam logic [IW-1:0] KSF_LAST = IW'(KSF - 1);
  localparam logic [IW-1:0] KHB_LAST = IW'(KHB - 1);
  localparam logic [1:0]    CODE_SF  = 2'b00;
  localparam logic [1:0]    CODE_HB  = 2'b01;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   payload;
  logic [1:0]      code;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   k_last;
  logic            last_grant;  // 1 = heartbeat was granted most recently
  logic            grant_sf, grant_hb;
  logic [PW-1:0]   sf_ext, hb_ext;
  logic [C-1:0]    chunk;
  logic            is_last;

  always_comb begin
    state_nx  = state;
    grant_sf  = 1'b0;
    grant_hb  = 1'b0;
    bus.sf_a  = 1'b0;
    bus.hb_a  = 1'b0;
    bus.out_v = 1'b0;
    bus.out_d = '0;
    sf_ext    = '0;
    hb_ext    = '0;
    sf_ext[W_SF-1:0] = bus.sf_d;
    hb_ext[W_HB-1:0] = bus.hb_d;
    chunk     = payload[int'(idx)*C +: C];
    is_last   = (idx == k_last);

    case (state)
      IDLE: begin
        // Reset gating keeps the combinational accepts low while reset is held.
        if (!reset) begin
          if (bus.sf_v && (!bus.hb_v || last_grant))
            grant_sf = 1'b1;
          else if (bus.hb_v)
            grant_hb = 1'b1;
        end
        bus.sf_a = grant_sf;
        bus.hb_a = grant_hb;
        if (grant_sf || grant_hb)
          state_nx = SEND;
      end
      SEND: begin
        bus.out_v = 1'b1;
        bus.out_d = {code, is_last, chunk};
        if (bus.out_a && is_last)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      payload    <= '0;
      code       <= 2'b00;
      idx        <= '0;
      k_last     <= '0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nx;
      if (grant_sf) begin
        payload    <= sf_ext;
        code       <= CODE_SF;
        k_last     <= KSF_LAST;
        idx        <= '0;
        last_grant <= 1'b0;
      end else if (grant_hb) begin
        payload    <= hb_ext;
        code       <= CODE_HB;
        k_last     <= KHB_LAST;
        idx        <= '0;
        last_grant <= 1'b1;
      end else if (state == SEND && bus.out_a && !is_last) begin
        idx <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pc_upstream_serializer.sv
// tb/tb_pc_upstream_serializer.sv - scoreboard bench for the upstream serializer
module tb_pc_upstream_serializer;
  localparam int NOUT = 16;
  localparam int NF   = 10;
  localparam int NS   = 27;
  localparam int NT   = 48;

  logic clk;
  logic reset;

  pc_upstream_serializer_if #(.Nout(NOUT), .N_SF_filts(NF), .N_SF_state(NS), .N_TM_time(NT)) bus ();

  pc_upstream_serializer #(.Nout(NOUT), .N_SF_filts(NF), .N_SF_state(NS), .N_TM_time(NT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [NF+NS-1:0] SF_A    = {10'h003, 27'h0000005};
  localparam logic [NF+NS-1:0] SF_ONES = {10'h3FF, 27'h7FFFFFF};

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [15:0] exp_q[$];
  int          grant_who[$];
  int          grant_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_sf_a();
    exp_q.push_back(16'h0005); exp_q.push_back(16'h0000); exp_q.push_back(16'h2006);
  endtask

  task automatic push_hb(input logic [3:0] lsb);
    exp_q.push_back({12'h400, lsb}); exp_q.push_back(16'h4000);
    exp_q.push_back(16'h4000);       exp_q.push_back(16'h6000);
  endtask

  task automatic monitor();
    logic [15:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (bus.sf_a) begin grant_who.push_back(0); grant_cyc.push_back(cyc); end
        if (bus.hb_a) begin grant_who.push_back(1); grant_cyc.push_back(cyc); end
        if (bus.out_v && bus.out_a) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", {48'h0, bus.out_d}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("out_d", {48'h0, bus.out_d}, {48'h0, e});
          end
        end
      end
    end
  endtask

  task automatic send_sf(input logic [NF+NS-1:0] d);
    logic seen;
    seen = 1'b0;
    @(posedge clk); #1;
    bus.sf_d = d;
    bus.sf_v = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.sf_a) begin seen = 1'b1; break; end
    end
    check("sf_accept_timeout", {63'h0, seen}, 64'h1);
    @(posedge clk); #1;
    bus.sf_v = 1'b0;
  endtask

  task automatic send_hb(input logic [NT-1:0] d);
    logic seen;
    seen = 1'b0;
    @(posedge clk); #1;
    bus.hb_d = d;
    bus.hb_v = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.hb_a) begin seen = 1'b1; break; end
    end
    check("hb_accept_timeout", {63'h0, seen}, 64'h1);
    @(posedge clk); #1;
    bus.hb_v = 1'b0;
  endtask

  task automatic wait_grants(input int n);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (grant_who.size() >= n) begin ok = 1'b1; break; end
    end
    check("grant_timeout", {63'h0, ok}, 64'h1);
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !bus.out_v) begin ok = 1'b1; break; end
    end
    check("drain_timeout", {63'h0, ok}, 64'h1);
  endtask

  initial begin
    bus.sf_v  = 1'b0;
    bus.sf_d  = '0;
    bus.hb_v  = 1'b0;
    bus.hb_d  = '0;
    bus.out_a = 1'b1;
    reset     = 1'b1;
    fork
      monitor();
    join_none

    // Reset state with both sources already valid, then the tie sequence.
    bus.sf_d = SF_A;
    bus.hb_d = 48'h1;
    bus.sf_v = 1'b1;
    bus.hb_v = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_v", {63'h0, bus.out_v}, 64'h0);
    check("reset_out_d", {48'h0, bus.out_d}, 64'h0);
    check("reset_sf_a",  {63'h0, bus.sf_a},  64'h0);
    check("reset_hb_a",  {63'h0, bus.hb_a},  64'h0);
    push_sf_a(); push_hb(4'h1); push_sf_a(); push_hb(4'h1);
    grant_who.delete(); grant_cyc.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    wait_grants(4);
    @(posedge clk); #1;
    bus.sf_v = 1'b0;
    bus.hb_v = 1'b0;
    if (grant_who.size() >= 4) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("tie_grant%0d", i), grant_who[i], i % 2);
      check("tie_gap_sf_hb", grant_cyc[1] - grant_cyc[0], 4);
      check("tie_gap_hb_sf", grant_cyc[2] - grant_cyc[1], 5);
      check("tie_gap_sf_hb2", grant_cyc[3] - grant_cyc[2], 4);
    end
    drain();

    // Single SF message: one-cycle accept, first word one cycle later.
    push_sf_a();
    send_sf(SF_A);
    @(negedge clk);
    check("sf_lat_out_v", {63'h0, bus.out_v}, 64'h1);
    check("sf_lat_out_d", {48'h0, bus.out_d}, 64'h0005);
    check("sf_a_one_cycle", {63'h0, bus.sf_a}, 64'h0);
    drain();

    // Single HB message.
    push_hb(4'h1);
    send_hb(48'h1);
    drain();

    // Back-pressure on the second HB word while another HB waits.
    push_hb(4'h1);
    send_hb(48'h1);
    @(posedge clk); #1;
    bus.out_a = 1'b0;
    bus.hb_d  = 48'h2;
    bus.hb_v  = 1'b1;
    push_hb(4'h2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_v", {63'h0, bus.out_v}, 64'h1);
      check("bp_out_d", {48'h0, bus.out_d}, 64'h4000);
      check("bp_hb_a",  {63'h0, bus.hb_a},  64'h0);
    end
    @(posedge clk); #1;
    bus.out_a = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (bus.hb_a) begin seen = 1'b1; break; end
      end
      check("bp_second_accept", {63'h0, seen}, 64'h1);
      @(posedge clk); #1;
      bus.hb_v = 1'b0;
    end
    drain();

    // Reset during the second SF word, then a fresh message from chunk 0.
    push_sf_a();
    send_sf(SF_A);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset_out_v", {63'h0, bus.out_v}, 64'h0);
    check("mid_reset_out_d", {48'h0, bus.out_d}, 64'h0);
    exp_q.push_back(16'h1FFF); exp_q.push_back(16'h1FFF); exp_q.push_back(16'h27FF);
    send_sf(SF_ONES);
    drain();

    // Last grant was SF; reset must hand the next tie back to SF.
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    grant_who.delete(); grant_cyc.delete();
    push_sf_a(); push_hb(4'h1);
    bus.sf_d = SF_A;
    bus.hb_d = 48'h1;
    bus.sf_v = 1'b1;
    bus.hb_v = 1'b1;
    wait_grants(2);
    @(posedge clk); #1;
    bus.sf_v = 1'b0;
    bus.hb_v = 1'b0;
    if (grant_who.size() >= 2) begin
      check("prio_first_sf",  grant_who[0], 0);
      check("prio_second_hb", grant_who[1], 1);
    end
    drain();

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
